// File: rtl/cla_pipe_adder_if.sv
// Streaming handshake bundle for cla_pipe_adder: operand side (in_*) and result side (out_*).
interface cla_pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   S;
  logic             Ovf;

  modport master (
    output in_valid, A, B, Cin, Sub, out_ready,
    input  in_ready, out_valid, S, Ovf
  );

  modport slave (
    input  in_valid, A, B, Cin, Sub, out_ready,
    output in_ready, out_valid, S, Ovf
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Optional build macro CLA_SAT_EN clamps the sum to signed saturation on overflow.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  cla_pipe_adder_if.slave  bus
);
  localparam int NGRP = WIDTH / GROUP;

  // Flow control
  logic w_adv2;
  logic w_in_ready;

  // Stage 1 combinational
  logic [WIDTH-1:0] w_beff;
  logic [WIDTH-1:0] w_p1;
  logic [WIDTH-1:0] w_g1;
  logic             w_c0;
  logic [NGRP-1:0]  w_gg1;
  logic [NGRP-1:0]  w_gp1;

  // Stage 1 registers
  logic             r_v1;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_g;
  logic [NGRP-1:0]  r_gg;
  logic [NGRP-1:0]  r_gp;
  logic             r_c0;
`ifdef CLA_SAT_EN
  logic             r_a_msb;
`endif

  // Stage 2 combinational
  logic [NGRP:0]    w_gc;
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;
  logic             w_prod;
  logic             w_acc;

  // Stage 2 registers
  logic             r_v2;
  logic [WIDTH:0]   r_s;
  logic             r_ovf;

  assign w_adv2        = ~r_v2 | bus.out_ready;
  assign w_in_ready    = ~r_v1 | w_adv2;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_v2;
  assign bus.S         = r_s;
  assign bus.Ovf       = r_ovf;

  // Operand conditioning for subtract, bit and group generate/propagate
  always_comb begin
    w_beff = bus.Sub ? ~bus.B : bus.B;
    w_c0   = bus.Sub ? 1'b1 : bus.Cin;
    w_p1   = bus.A ^ w_beff;
    w_g1   = bus.A & w_beff;
    w_gg1  = {NGRP{1'b0}};
    w_gp1  = {NGRP{1'b1}};
    for (int j = 0; j < NGRP; j++) begin
      for (int k = 0; k < GROUP; k++) begin
        w_gg1[j] = w_g1[j*GROUP+k] | (w_p1[j*GROUP+k] & w_gg1[j]);
        w_gp1[j] = w_gp1[j] & w_p1[j*GROUP+k];
      end
    end
  end

  // Stage 1 register: captures only on an accepted transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p  <= {WIDTH{1'b0}};
      r_g  <= {WIDTH{1'b0}};
      r_gg <= {NGRP{1'b0}};
      r_gp <= {NGRP{1'b0}};
      r_c0 <= 1'b0;
`ifdef CLA_SAT_EN
      r_a_msb <= 1'b0;
`endif
    end else if (w_in_ready && bus.in_valid) begin
      r_p  <= w_p1;
      r_g  <= w_g1;
      r_gg <= w_gg1;
      r_gp <= w_gp1;
      r_c0 <= w_c0;
`ifdef CLA_SAT_EN
      r_a_msb <= bus.A[WIDTH-1];
`endif
    end
  end

  // Second-level lookahead: each group carry is a flat sum of products over (GG, GP, c0)
  always_comb begin
    w_prod = 1'b1;
    w_acc  = 1'b0;
    w_gc   = {(NGRP+1){1'b0}};
    w_gc[0] = r_c0;
    for (int j = 0; j < NGRP; j++) begin
      w_prod = 1'b1;
      w_acc  = 1'b0;
      for (int k = j; k >= 0; k--) begin
        w_acc  = w_acc | (w_prod & r_gg[k]);
        w_prod = w_prod & r_gp[k];
      end
      w_gc[j+1] = w_acc | (w_prod & r_c0);
    end
    w_c = {(WIDTH+1){1'b0}};
    for (int j = 0; j < NGRP; j++) begin
      w_c[j*GROUP] = w_gc[j];
      for (int k = 1; k < GROUP; k++) begin
        w_c[j*GROUP+k] = r_g[j*GROUP+k-1] | (r_p[j*GROUP+k-1] & w_c[j*GROUP+k-1]);
      end
    end
    w_c[WIDTH] = w_gc[NGRP];
    w_sum = r_p ^ w_c[WIDTH-1:0];
    w_ovf = w_c[WIDTH] ^ w_c[WIDTH-1];
`ifdef CLA_SAT_EN
    if (w_ovf) begin
      w_sum = r_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      w_sum = r_p ^ w_c[WIDTH-1:0];
    end
`endif
  end

  // Valid bits and stage 2 result; result holds while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_s   <= {(WIDTH+1){1'b0}};
      r_ovf <= 1'b0;
    end else begin
      if (w_adv2) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_s   <= {w_c[WIDTH], w_sum};
          r_ovf <= w_ovf;
        end
      end
      if (w_in_ready) begin
        r_v1 <= bus.in_valid;
      end
    end
  end
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder (WIDTH=16): directed table plus handshake sequences.
module tb_cla_pipe_adder;
  localparam int W = 16;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [16:0] s;
    logic        ovf;
  } vec_t;

`ifdef CLA_SAT_EN
  localparam logic [16:0] S_7FFF_P1  = 17'h07FFF;
  localparam logic [16:0] S_8000_M1  = 17'h18000;
  localparam logic [16:0] S_8000_P8K = 17'h18000;
  localparam logic [16:0] S_7FFF_MN1 = 17'h07FFF;
`else
  localparam logic [16:0] S_7FFF_P1  = 17'h08000;
  localparam logic [16:0] S_8000_M1  = 17'h17FFF;
  localparam logic [16:0] S_8000_P8K = 17'h10000;
  localparam logic [16:0] S_7FFF_MN1 = 17'h08000;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cla_pipe_adder_if #(.WIDTH(W)) bus ();
  cla_pipe_adder #(.WIDTH(W), .GROUP(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  logic [16:0] got_s[$];
  logic        got_o[$];
  int          got_t[$];
  logic [16:0] exp_s[$];
  logic        exp_o[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      got_s.push_back(bus.S);
      got_o.push_back(bus.Ovf);
      got_t.push_back(cyc);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub);
    bus.in_valid = v;
    bus.A        = a;
    bus.B        = b;
    bus.Cin      = cin;
    bus.Sub      = sub;
  endtask

  function automatic logic [17:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
    logic [15:0] be;
    logic [16:0] s;
    logic        ov;
    be = sub ? ~b : b;
    s  = {1'b0, a} + {1'b0, be} + {16'd0, (sub ? 1'b1 : cin)};
    ov = (a[15] == be[15]) && (s[15] != a[15]);
`ifdef CLA_SAT_EN
    if (ov) s[15:0] = a[15] ? 16'h8000 : 16'h7FFF;
`endif
    return {ov, s};
  endfunction

  task automatic clear_q();
    got_s.delete(); got_o.delete(); got_t.delete();
    exp_s.delete(); exp_o.delete();
  endtask

  task automatic cmp_q(input string name, input int n);
    chk({name, "_count"}, got_s.size(), n);
    for (int i = 0; i < n && i < got_s.size() && i < exp_s.size(); i++) begin
      chk({name, "_S"}, {15'd0, got_s[i]}, {15'd0, exp_s[i]});
      chk({name, "_Ovf"}, {31'd0, got_o[i]}, {31'd0, exp_o[i]});
    end
  endtask

  vec_t tv[13];
  vec_t bp[4];
  logic [17:0] r;
  logic        acc;
  logic        all_ready;
  int          idx;
  int          lat;
  logic [15:0] ra, rb;
  logic        rc, rsub;

  initial begin
    tv[0]  = '{16'h1234, 16'h0F0F, 1'b1, 1'b0, 17'h02144, 1'b0};
    tv[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 1'b0};
    tv[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, S_7FFF_P1, 1'b1};
    tv[3]  = '{16'h0005, 16'h0005, 1'b1, 1'b1, 17'h10000, 1'b0};
    tv[4]  = '{16'h0003, 16'h0005, 1'b0, 1'b1, 17'h0FFFE, 1'b0};
    tv[5]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, S_8000_M1, 1'b1};
    tv[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, S_8000_P8K, 1'b1};
    tv[7]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 17'h1FFFF, 1'b0};
    tv[8]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 17'h00001, 1'b0};
    tv[9]  = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, S_7FFF_MN1, 1'b1};
    tv[10] = '{16'hAAAA, 16'h5555, 1'b0, 1'b0, 17'h0FFFF, 1'b0};
    tv[11] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 17'h01000, 1'b0};
    tv[12] = '{16'h0010, 16'h0001, 1'b0, 1'b1, 17'h1000F, 1'b0};

    bp[0] = '{16'h0001, 16'h0002, 1'b0, 1'b0, 17'h0, 1'b0};
    bp[1] = '{16'h1000, 16'h0FFF, 1'b1, 1'b0, 17'h0, 1'b0};
    bp[2] = '{16'h0100, 16'h0200, 1'b0, 1'b1, 17'h0, 1'b0};
    bp[3] = '{16'h4000, 16'h4000, 1'b0, 1'b0, 17'h0, 1'b0};

    // Reset
    rst = 1'b1;
    bus.out_ready = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_S", {15'd0, bus.S}, 32'd0);
    chk("rst_Ovf", {31'd0, bus.Ovf}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Directed table, one vector at a time, checking latency too
    for (int i = 0; i < 13; i++) begin
      @(posedge clk);
      #1;
      drive(1'b1, tv[i].a, tv[i].b, tv[i].cin, tv[i].sub);
      bus.out_ready = 1'b1;
      lat = 0;
      for (int k = 0; k < 6; k++) begin
        @(posedge clk);
        #1;
        if (k == 0) bus.in_valid = 1'b0;
        lat++;
        if (bus.out_valid) break;
      end
      chk($sformatf("vec%0d_latency", i), lat, 32'd2);
      chk($sformatf("vec%0d_S", i), {15'd0, bus.S}, {15'd0, tv[i].s});
      chk($sformatf("vec%0d_Ovf", i), {31'd0, bus.Ovf}, {31'd0, tv[i].ovf});
    end
    @(posedge clk);
    #1;

    // Backpressure: fill both stages with out_ready low
    clear_q();
    bus.out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6 && idx < 4; c++) begin
      drive(1'b1, bp[idx].a, bp[idx].b, bp[idx].cin, bp[idx].sub);
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        r = ref_add(bp[idx].a, bp[idx].b, bp[idx].cin, bp[idx].sub);
        exp_s.push_back(r[16:0]);
        exp_o.push_back(r[17]);
        idx++;
      end
    end
    chk("bp_accepted_before_stall", idx, 32'd2);
    r = ref_add(bp[0].a, bp[0].b, bp[0].cin, bp[0].sub);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_S_hold", {15'd0, bus.S}, {15'd0, r[16:0]});
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_on_release", {31'd0, bus.in_ready}, 32'd1);
    chk("bp_out_valid_on_release", {31'd0, bus.out_valid}, 32'd1);
    acc = bus.in_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      r = ref_add(bp[idx].a, bp[idx].b, bp[idx].cin, bp[idx].sub);
      exp_s.push_back(r[16:0]);
      exp_o.push_back(r[17]);
      idx++;
    end
    for (int c = 0; c < 10 && idx < 4; c++) begin
      drive(1'b1, bp[idx].a, bp[idx].b, bp[idx].cin, bp[idx].sub);
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        r = ref_add(bp[idx].a, bp[idx].b, bp[idx].cin, bp[idx].sub);
        exp_s.push_back(r[16:0]);
        exp_o.push_back(r[17]);
        idx++;
      end
    end
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    cmp_q("bp", 4);

    // Back-to-back throughput with random operands
    clear_q();
    all_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rc   = 1'($urandom);
      rsub = 1'($urandom);
      drive(1'b1, ra, rb, rc, rsub);
      @(negedge clk);
      if (!bus.in_ready) all_ready = 1'b0;
      @(posedge clk);
      #1;
      r = ref_add(ra, rb, rc, rsub);
      exp_s.push_back(r[16:0]);
      exp_o.push_back(r[17]);
    end
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("tp_in_ready_always", {31'd0, all_ready}, 32'd1);
    cmp_q("tp", 32);
    if (got_t.size() == 32) begin
      chk("tp_consecutive", got_t[31] - got_t[0], 32'd31);
    end else begin
      chk("tp_consecutive_count", got_t.size(), 32'd32);
    end

    // Reset with both stages full
    clear_q();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 16'h1111 * (i + 1), 16'h0101, 1'b0, 1'b0);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("mr_full_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("mr_full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mr_v1", {31'd0, dut.r_v1}, 32'd0);
    chk("mr_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mr_S", {15'd0, bus.S}, 32'd0);
    chk("mr_Ovf", {31'd0, bus.Ovf}, 32'd0);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("mr_no_stale", got_s.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
